// File: rtl/hub75_fb_writer.sv
// Raster pixel stream -> back bank of a double-buffered framebuffer; one-cycle registered write.
// s_ready drops only while a full frame waits for the display's end-of-frame to swap banks.
module hub75_fb_writer #(
  parameter  int WIDTH     = 64,
  parameter  int HEIGHT    = 64,
  parameter  int BIT_DEPTH = 8,
  localparam int XW        = $clog2(WIDTH),
  localparam int YW        = $clog2(HEIGHT),
  localparam int DW        = 3 * BIT_DEPTH,
  localparam int AW        = 1 + YW + XW
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          s_sof,
  input  logic          s_eol,
  output logic          fb_we,
  output logic [AW-1:0] fb_waddr,
  output logic [DW-1:0] fb_wdata,
  input  logic          disp_frame_done,
  output logic          disp_bank,
  output logic          frame_err,
  output logic [15:0]   frame_count
);

  typedef enum logic [1:0] {IDLE, WRITE, WAIT_SWAP} state_t;

  state_t        state, state_nxt;
  logic [XW-1:0] x, x_nxt;
  logic [YW-1:0] y, y_nxt;
  logic          bank_nxt, we_nxt, err_nxt;
  logic [AW-1:0] addr_nxt;
  logic [DW-1:0] wdata_nxt;
  logic [15:0]   count_nxt;
  logic          xfer, last_x, last_y;

  assign s_ready = (state != WAIT_SWAP);
  assign xfer    = s_valid && s_ready;
  assign last_x  = (x == XW'(WIDTH - 1));
  assign last_y  = (y == YW'(HEIGHT - 1));

  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    bank_nxt  = disp_bank;
    count_nxt = frame_count;
    we_nxt    = 1'b0;
    err_nxt   = 1'b0;
    addr_nxt  = fb_waddr;
    wdata_nxt = fb_wdata;

    unique case (state)
      IDLE: begin
        // Anything before the first start-of-frame is dropped silently.
        if (xfer && s_sof) begin
          we_nxt    = 1'b1;
          addr_nxt  = {~disp_bank, {YW{1'b0}}, {XW{1'b0}}};
          wdata_nxt = s_data;
          x_nxt     = XW'(1);
          y_nxt     = '0;
          state_nxt = WRITE;
        end
      end

      WRITE: begin
        if (xfer) begin
          we_nxt    = 1'b1;
          wdata_nxt = s_data;
          if (s_sof) begin
            addr_nxt = {~disp_bank, {YW{1'b0}}, {XW{1'b0}}};
            err_nxt  = 1'b1;
            x_nxt    = XW'(1);
            y_nxt    = '0;
          end else begin
            addr_nxt = {~disp_bank, y, x};
            if (s_eol || last_x) begin
              // Short or overlong rows still advance; the mismatch is flagged.
              err_nxt = s_eol ^ last_x;
              x_nxt   = '0;
              if (last_y) begin
                y_nxt     = '0;
                state_nxt = WAIT_SWAP;
              end else begin
                y_nxt = y + YW'(1);
              end
            end else begin
              x_nxt = x + XW'(1);
            end
          end
        end
      end

      WAIT_SWAP: begin
        if (disp_frame_done) begin
          bank_nxt  = ~disp_bank;
          count_nxt = frame_count + 16'd1;
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      disp_bank   <= 1'b0;
      fb_we       <= 1'b0;
      fb_waddr    <= '0;
      fb_wdata    <= '0;
      frame_err   <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= state_nxt;
      x           <= x_nxt;
      y           <= y_nxt;
      disp_bank   <= bank_nxt;
      fb_we       <= we_nxt;
      fb_waddr    <= addr_nxt;
      fb_wdata    <= wdata_nxt;
      frame_err   <= err_nxt;
      frame_count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_hub75_fb_writer.sv
// Randomized bench for hub75_fb_writer against a frame-level reference model.
module tb_hub75_fb_writer;

  localparam int W  = 64;
  localparam int H  = 64;
  localparam int BD = 8;
  localparam int DW = 3 * BD;
  localparam int AW = 1 + $clog2(H) + $clog2(W);

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_sof = 1'b0;
  logic          s_eol = 1'b0;
  logic          fb_we;
  logic [AW-1:0] fb_waddr;
  logic [DW-1:0] fb_wdata;
  logic          disp_frame_done = 1'b0;
  logic          disp_bank;
  logic          frame_err;
  logic [15:0]   frame_count;

  hub75_fb_writer #(.WIDTH(W), .HEIGHT(H), .BIT_DEPTH(BD)) dut (
    .CLK(CLK), .RST(RST),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_sof(s_sof), .s_eol(s_eol),
    .fb_we(fb_we), .fb_waddr(fb_waddr), .fb_wdata(fb_wdata),
    .disp_frame_done(disp_frame_done), .disp_bank(disp_bank),
    .frame_err(frame_err), .frame_count(frame_count)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int n_we    = 0;
  int n_err   = 0;

  // Reference model: frame position, whether a frame is in progress or complete.
  bit m_active, m_wait, m_bank;
  int m_x, m_y, m_count;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_wait = 0; m_bank = 0;
    m_x = 0; m_y = 0; m_count = 0;
  endtask

  // One clock: drive inputs, predict, clock, compare every output.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit sof, input bit eol,
                      input bit done);
    bit ew, ee, swap;
    int base;
    logic [AW-1:0] ea;
    ew = 0; ee = 0; ea = '0;
    s_valid = v; s_data = d; s_sof = sof; s_eol = eol; disp_frame_done = done;
    chk("s_ready", 32'(s_ready), 32'(!m_wait));
    swap = m_wait && done;
    base = m_bank ? 0 : W * H;
    if (v && !m_wait) begin
      if (!m_active) begin
        if (sof) begin
          ew = 1; ea = AW'(base); m_active = 1; m_x = 1; m_y = 0;
        end
      end else if (sof) begin
        ew = 1; ee = 1; ea = AW'(base); m_x = 1; m_y = 0;
      end else begin
        ew = 1;
        ea = AW'(base + m_y * W + m_x);
        if (eol || m_x == W - 1) begin
          ee = (eol != (m_x == W - 1));
          m_x = 0;
          m_y++;
          if (m_y == H) begin
            m_y = 0; m_active = 0; m_wait = 1;
          end
        end else begin
          m_x++;
        end
      end
    end
    if (swap) begin
      m_bank = !m_bank; m_count = (m_count + 1) % 65536; m_wait = 0;
    end
    @(posedge CLK);
    #1;
    if (fb_we === 1'b1) n_we++;
    if (frame_err === 1'b1) n_err++;
    chk("fb_we", 32'(fb_we), 32'(ew));
    if (ew) begin
      chk("fb_waddr", 32'(fb_waddr), 32'(ea));
      chk("fb_wdata", 32'(fb_wdata), 32'(d));
    end
    chk("frame_err", 32'(frame_err), 32'(ee));
    chk("disp_bank", 32'(disp_bank), 32'(m_bank));
    chk("frame_count", 32'(frame_count), 32'(m_count));
  endtask

  // mode 0 clean (address-pattern data), 1 early eol at (20,3),
  // 2 restart sof at (5,10), 3 random framing faults.
  task automatic drive_frame(input int mode, input bit gaps, input bit done_last);
    bit first, used, sof, eol, done;
    int guard;
    logic [DW-1:0] d;
    first = 1; used = 0; guard = 0;
    while (!m_wait && guard < 20000) begin
      guard++;
      if (gaps && $urandom_range(0, 3) == 0)
        step(0, DW'($urandom), 0, 0, 1'($urandom_range(0, 7) == 0));
      sof = first;
      eol = (m_x == W - 1);
      if (mode == 1 && !used && m_y == 3 && m_x == 20) begin eol = 1; used = 1; end
      if (mode == 2 && !used && m_y == 10 && m_x == 5) begin sof = 1; used = 1; end
      if (mode == 3) begin
        if ($urandom_range(0, 199) == 0) eol = !eol;
        if ($urandom_range(0, 1999) == 0) sof = 1;
      end
      d = (mode == 0) ? DW'((m_bank ? 0 : W * H) + m_y * W + m_x) : DW'($urandom);
      done = done_last && m_active && !sof && m_y == H - 1 && (eol || m_x == W - 1);
      step(1, d, sof, eol, done);
      first = 0;
    end
    chk("frame_bound", 32'(m_wait), 32'(1));
  endtask

  task automatic swap_after(input int dly);
    repeat (dly) step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)), 0, 0);
    step(0, '0, 0, 0, 1);
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_we", 32'(fb_we), 32'(0));
    chk("rst_waddr", 32'(fb_waddr), 32'(0));
    chk("rst_wdata", 32'(fb_wdata), 32'(0));
    chk("rst_err", 32'(frame_err), 32'(0));
    chk("rst_bank", 32'(disp_bank), 32'(0));
    chk("rst_count", 32'(frame_count), 32'(0));
    chk("rst_ready", 32'(s_ready), 32'(1));
    @(negedge CLK);
    RST = 1'b0;

    n_we = 0; n_err = 0;
    drive_frame(0, 0, 0);
    chk("frame1_we_count", 32'(n_we), 32'(W * H));
    chk("frame1_err_count", 32'(n_err), 32'(0));
    swap_after(3);

    drive_frame(0, 1, 0);
    swap_after(5);

    n_we = 0;
    repeat (10) step(1, DW'($urandom), 0, 1'($urandom_range(0, 1)), 0);
    chk("nosof_we_count", 32'(n_we), 32'(0));
    drive_frame(1, 1, 0);
    swap_after(2);

    n_err = 0;
    drive_frame(2, 0, 0);
    chk("restart_err_count", 32'(n_err), 32'(1));
    swap_after(0);

    drive_frame(0, 0, 1);
    repeat (100) step(0, '0, 0, 0, 0);
    step(0, '0, 0, 0, 1);

    drive_frame(3, 1, 0);
    swap_after(1);

    step(1, DW'($urandom), 1, 0, 0);
    repeat (30) step(1, DW'($urandom), 0, 0, 0);
    RST = 1'b1;
    #1;
    model_reset();
    chk("midrst_bank", 32'(disp_bank), 32'(0));
    chk("midrst_ready", 32'(s_ready), 32'(1));
    chk("midrst_we", 32'(fb_we), 32'(0));
    chk("midrst_count", 32'(frame_count), 32'(0));
    @(negedge CLK);
    RST = 1'b0;
    drive_frame(0, 1, 0);
    swap_after(1);
    step(0, '0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
